// File: rtl/dds_nco_iq.sv
// dds_nco_iq
//   Quadrature numerically controlled oscillator built from plain RTL. A phase
//   accumulator steps by the frequency tuning word on each enabled clock. The
//   phase plus a programmable offset addresses a quarter-wave sine ROM, and the
//   ROM output is folded into four-quadrant signed sine and cosine samples.
//   One sample is produced per enabled clock. A sample appears four edges after
//   the edge that captured it.
//
// Ports
//   clk          clock
//   rst          asynchronous reset, active high
//   i_en         advance the accumulator and launch one sample this cycle
//   i_clr        synchronous accumulator clear (phase restart)
//   i_cfg_valid  one-cycle strobe that loads i_ftw and i_poff together
//   i_ftw        frequency tuning word, f_out = FTW * f_clk / 2^ACC_W
//   i_poff       phase offset added to the accumulator before lookup
//   o_sin/o_cos  signed two's-complement sine / cosine
//   o_valid      o_sin/o_cos carry a new sample
//
// Optional feature macro: DDS_DITHER_EN
//   When defined, a 16-bit LFSR adds dither below the ROM address LSB before
//   truncation. This spreads the truncation spurs.
//   This assumes ACC_W > LUT_AW + 2.
//   When undefined, plain truncation is used.
module dds_nco_iq #(
  parameter int ACC_W  = 32,
  parameter int LUT_AW = 10,
  parameter int OUT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_cfg_valid,
  input  logic [ACC_W-1:0] i_ftw,
  input  logic [ACC_W-1:0] i_poff,
  output logic [OUT_W-1:0] o_sin,
  output logic [OUT_W-1:0] o_cos,
  output logic             o_valid
);

  localparam int  DEPTH  = 1 << LUT_AW;
  localparam int  AMP    = (1 << (OUT_W - 1)) - 1;
  localparam int  FRAC_W = ACC_W - LUT_AW - 2;
  localparam real PI     = 3.14159265358979323846;

  // Quarter-wave table sampled at half-step angles. The half-step offset
  // makes every entry non-zero. It also makes sine and cosine of the same
  // phase land on complementary addresses (a and ~a).
  logic [OUT_W-2:0] rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam real ANGLE = (real'(k) + 0.5) * PI / real'(2 * DEPTH);
    localparam int  VALUE = $rtoi(real'(AMP) * $sin(ANGLE) + 0.5);
    assign rom[k] = VALUE[OUT_W-2:0];
  end

  logic [ACC_W-1:0] ftw_r;
  logic [ACC_W-1:0] poff_r;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] phase_sum;
  logic             unused_frac;

  // Tuning word and offset are loaded together so a retune never mixes an
  // old frequency with a new offset. Same-edge users still see the old values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ftw_r  <= '0;
      poff_r <= '0;
    end else if (i_cfg_valid) begin
      ftw_r  <= i_ftw;
      poff_r <= i_poff;
    end
  end

  // Phase accumulator. Clear wins over enable. The sum wraps modulo 2^ACC_W,
  // which is exactly the periodicity of the phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (i_clr) begin
      acc <= '0;
    end else if (i_en) begin
      acc <= acc + ftw_r;
    end
  end

`ifdef DDS_DITHER_EN
  localparam int DITH_W = (FRAC_W < 16) ? FRAC_W : 16;

  logic [15:0]      lfsr;
  logic [ACC_W-1:0] dither_add;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1. It steps once per launched sample,
  // so the dither sequence is tied to the sample stream, not to idle clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else if (i_en) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // The top LFSR bits are aligned just under the ROM address LSB. The carry
  // into the address then randomises the truncation error.
  always_comb begin
    dither_add = ACC_W'(lfsr[15 -: DITH_W]) << (FRAC_W - DITH_W);
    phase_sum  = acc + poff_r + dither_add;
  end
`else
  // Lookup phase uses the pre-increment accumulator and the current offset.
  always_comb begin
    phase_sum = acc + poff_r;
  end
`endif

  // The truncated fraction bits are intentionally dropped.
  assign unused_frac = ^{1'b0, phase_sum};

  logic                ph_valid;
  logic [LUT_AW+1:0]   ph_top;
  logic                addr_valid;
  logic [1:0]          addr_quad;
  logic [LUT_AW-1:0]   addr_sin;
  logic [LUT_AW-1:0]   addr_cos;
  logic                rom_valid;
  logic [1:0]          rom_quad;
  logic [OUT_W-2:0]    rom_sin;
  logic [OUT_W-2:0]    rom_cos;
  logic                fold_valid;
  logic [OUT_W-1:0]    fold_sin;
  logic [OUT_W-1:0]    fold_cos;
  logic signed [OUT_W-1:0] mag_sin;
  logic signed [OUT_W-1:0] mag_cos;
  logic signed [OUT_W-1:0] next_sin;
  logic signed [OUT_W-1:0] next_cos;

  // Phase capture. Only the quadrant and ROM address bits are kept.
  // Each pipeline stage loads data only alongside its valid bit and holds
  // otherwise, so gaps never expose stale or unknown data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_valid <= 1'b0;
      ph_top   <= '0;
    end else begin
      ph_valid <= i_en;
      if (i_en) begin
        ph_top <= phase_sum[ACC_W-1 -: LUT_AW+2];
      end
    end
  end

  // Address register in front of the ROM. Sine reads address a. Cosine reads
  // the mirrored address ~a, which is the quarter-wave complement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_valid <= 1'b0;
      addr_quad  <= '0;
      addr_sin   <= '0;
      addr_cos   <= '0;
    end else begin
      addr_valid <= ph_valid;
      if (ph_valid) begin
        addr_quad <= ph_top[LUT_AW+1 -: 2];
        addr_sin  <= ph_top[LUT_AW-1:0];
        addr_cos  <= ~ph_top[LUT_AW-1:0];
      end
    end
  end

  // Registered dual-port ROM read. Port A serves sine and port B serves cosine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_valid <= 1'b0;
      rom_quad  <= '0;
      rom_sin   <= '0;
      rom_cos   <= '0;
    end else begin
      rom_valid <= addr_valid;
      if (addr_valid) begin
        rom_quad <= addr_quad;
        rom_sin  <= rom[addr_sin];
        rom_cos  <= rom[addr_cos];
      end
    end
  end

  // Quadrant fold: choose which magnitude feeds each output and its sign.
  // Magnitudes never exceed AMP, so negation is always exact.
  always_comb begin
    mag_sin  = $signed({1'b0, rom_sin});
    mag_cos  = $signed({1'b0, rom_cos});
    next_sin = mag_sin;
    next_cos = mag_cos;
    case (rom_quad)
      2'd0: begin
        next_sin = mag_sin;
        next_cos = mag_cos;
      end
      2'd1: begin
        next_sin = mag_cos;
        next_cos = -mag_sin;
      end
      2'd2: begin
        next_sin = -mag_sin;
        next_cos = -mag_cos;
      end
      default: begin
        next_sin = -mag_cos;
        next_cos = mag_sin;
      end
    endcase
  end

  // Fold result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fold_valid <= 1'b0;
      fold_sin   <= '0;
      fold_cos   <= '0;
    end else begin
      fold_valid <= rom_valid;
      if (rom_valid) begin
        fold_sin <= next_sin;
        fold_cos <= next_cos;
      end
    end
  end

  // Output register. o_valid trails i_en by exactly four edges. The outputs
  // hold the last sample between valids.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_sin   <= '0;
      o_cos   <= '0;
    end else begin
      o_valid <= fold_valid;
      if (fold_valid) begin
        o_sin <= fold_sin;
        o_cos <= fold_cos;
      end
    end
  end

endmodule
